// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue controller and anything that talks to it.
//   - ALU control code constants (integer, multiply, buffer and FP code range)
//   - FSM state encoding for the issue controller
//   - Small helpers that classify a control code
package alu_issue_ctrl_pkg;

  localparam logic [4:0] ALU_ADD        = 5'd2;
  localparam logic [4:0] ALU_MUL        = 5'd5;
  localparam logic [4:0] ALU_SUB        = 5'd6;
  localparam logic [4:0] ALU_MULU       = 5'd21;
  localparam logic [4:0] ALU_BUF        = 5'd22;
  localparam logic [4:0] ALU_FP_FIRST   = 5'd23;
  localparam logic [4:0] ALU_FP_LAST    = 5'd29;
  localparam logic [4:0] ALU_LAST_LEGAL = 5'd29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_t;

  // FP operations use the FP latency, everything else the integer latency.
  function automatic logic is_fp_code(input logic [4:0] code);
    return (code >= ALU_FP_FIRST) && (code <= ALU_FP_LAST);
  endfunction

  // Codes above the last legal one never reach the ALU result path.
  function automatic logic is_illegal_code(input logic [4:0] code);
    return code > ALU_LAST_LEGAL;
  endfunction

  // Only the two multiplies produce a 64-bit result worth keeping in HI/LO.
  function automatic logic writes_hilo(input logic [4:0] code);
    return (code == ALU_MUL) || (code == ALU_MULU);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues one operation at a time to an external ALU, waits a fixed latency
//   (FP_LAT for FP codes, INT_LAT otherwise, each 1..7), captures the result
//   and holds it as a response until the consumer accepts it. Multiplies also
//   update the HI/LO architectural registers. Illegal codes (30, 31) skip the
//   ALU and return an error response immediately.
//
// Ports
//   clk, rst                 clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_ctrl/req_a/req_b     ALU control code and operands
//   req_tag                  destination tag, echoed on resp_tag
//   alu_ctrl/alu_a/alu_b     registered operation driven to the ALU
//   alu_out/alu_out_high     ALU low/high result
//   alu_zero/alu_overflow    ALU flags
//   resp_valid/resp_ready    response handshake
//   resp_data/resp_tag       captured result and its tag
//   resp_zero/resp_overflow  captured flags
//   resp_err                 set for illegal control codes
//   hi_q/lo_q                HI/LO architectural registers
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int FP_LAT  = 2,
  parameter int INT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_ctrl,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  output logic [4:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_out_high,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_tag,
  output logic        resp_zero,
  output logic        resp_overflow,
  output logic        resp_err,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  // Counter is preloaded with L-1 so that the capture lands exactly L edges
  // after the accept edge.
  localparam logic [2:0] FP_LOAD  = 3'(FP_LAT - 1);
  localparam logic [2:0] INT_LOAD = 3'(INT_LAT - 1);

  issue_state_t state_q;
  issue_state_t state_d;
  logic [2:0]   count_q;
  logic [4:0]   tag_q;
  logic         accept;
  logic         capture;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign capture = (state_q == ST_EXEC) && (count_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Illegal codes bypass EXEC entirely; RESP only leaves on the handshake,
  // and IDLE is the only state that accepts, so requests never overlap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = is_illegal_code(req_ctrl) ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (count_q == 3'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
  end

  // Response registers change only at a capture edge (or at an illegal
  // accept), so they stay frozen for the whole RESP stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= 3'd0;
      alu_ctrl      <= ALU_BUF;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      tag_q         <= 5'd0;
      resp_data     <= 32'd0;
      resp_tag      <= 5'd0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_err      <= 1'b0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
    end else if (accept) begin
      alu_ctrl <= req_ctrl;
      alu_a    <= req_a;
      alu_b    <= req_b;
      tag_q    <= req_tag;
      if (is_illegal_code(req_ctrl)) begin
        count_q       <= 3'd0;
        resp_data     <= 32'd0;
        resp_tag      <= req_tag;
        resp_zero     <= 1'b1;
        resp_overflow <= 1'b0;
        resp_err      <= 1'b1;
      end else begin
        count_q <= is_fp_code(req_ctrl) ? FP_LOAD : INT_LOAD;
      end
    end else if (capture) begin
      resp_data     <= alu_out;
      resp_tag      <= tag_q;
      resp_zero     <= alu_zero;
      resp_overflow <= alu_overflow;
      resp_err      <= 1'b0;
      if (writes_hilo(alu_ctrl)) begin
        hi_q <= alu_out_high;
        lo_q <= alu_out;
      end
    end else if (state_q == ST_EXEC) begin
      count_q <= count_q - 3'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl. A behavioural ALU sits beside the
//   DUT driving alu_out/alu_out_high/flags from the DUT's registered operation.
//   Each transaction is checked against expectations derived from the
//   operation: latency in edges, returned data/flags/tag, HI/LO contents and
//   handshake behaviour, plus directed reset and corner cases.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int FP_LAT  = 2;
  localparam int INT_LAT = 1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        ovf;
  } alu_res_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_ctrl;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [31:0] alu_out_high;
  logic        alu_zero;
  logic        alu_overflow;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_zero;
  logic        resp_overflow;
  logic        resp_err;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  int          tests_run;
  int          tests_failed;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  alu_res_t    stub_res;

  alu_issue_ctrl #(
    .FP_LAT (FP_LAT),
    .INT_LAT(INT_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ctrl     (req_ctrl),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .alu_ctrl     (alu_ctrl),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_out_high (alu_out_high),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_tag     (resp_tag),
    .resp_zero    (resp_zero),
    .resp_overflow(resp_overflow),
    .resp_err     (resp_err),
    .hi_q         (hi_q),
    .lo_q         (lo_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single precision <-> double precision by field re-biasing, so the FP add
  // can be done with real arithmetic; denormals flush to zero.
  function automatic logic [63:0] sp_to_dp(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return {s[31], 63'd0};
    e = (s[30:23] == 8'hFF) ? 11'h7FF : (11'(s[30:23]) + 11'd896);
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp_to_sp(input logic [63:0] d);
    int e;
    e = int'(d[62:52]);
    if (e == 0) return {d[63], 31'd0};
    if (e == 2047) return {d[63], 8'hFF, d[51:29]};
    e = e - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  // Behavioural ALU: integer add/sub with signed overflow, signed and
  // unsigned multiply, FP add for code 23, and a scrambling function with a
  // non-trivial high word for every other code.
  function automatic alu_res_t alu_model(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    alu_res_t    r;
    logic [63:0] p;
    r = '0;
    if (c == ALU_ADD) begin
      r.lo  = a + b;
      r.ovf = (a[31] == b[31]) && (r.lo[31] != a[31]);
    end else if (c == ALU_SUB) begin
      r.lo  = a - b;
      r.ovf = (a[31] != b[31]) && (r.lo[31] != a[31]);
    end else if (c == ALU_MUL) begin
      p    = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (c == ALU_MULU) begin
      p    = {32'd0, a} * {32'd0, b};
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (c == ALU_FP_FIRST) begin
      r.lo = dp_to_sp($realtobits($bitstoreal(sp_to_dp(a)) + $bitstoreal(sp_to_dp(b))));
    end else begin
      r.lo  = a ^ (b + {27'd0, c});
      r.hi  = ~r.lo;
      r.ovf = a[0] & b[0];
    end
    r.zero = (r.lo == 32'd0);
    return r;
  endfunction

  always_comb begin
    stub_res     = alu_model(alu_ctrl, alu_a, alu_b);
    alu_out      = stub_res.lo;
    alu_out_high = stub_res.hi;
    alu_zero     = stub_res.zero;
    alu_overflow = stub_res.ovf;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction: accept, wait for the response, hold it for
  // 'stall' cycles, then hand it off while a competing request is offered.
  task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input int stall);
    alu_res_t    r;
    int          lat;
    int          n;
    logic        illegal;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_ovf;
    illegal = (ctrl > ALU_LAST_LEGAL);
    if (illegal) lat = 0;
    else if (ctrl >= ALU_FP_FIRST && ctrl <= ALU_FP_LAST) lat = FP_LAT;
    else lat = INT_LAT;

    checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_ctrl  = ctrl;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("alu_ctrl_issued", 64'(alu_ctrl), 64'(ctrl));
    checkOutput("alu_a_issued", 64'(alu_a), 64'(a));
    checkOutput("alu_b_issued", 64'(alu_b), 64'(b));

    n = 0;
    while (!resp_valid && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", 64'(n), 64'(lat));

    if (illegal) begin
      exp_data = 32'd0;
      exp_zero = 1'b1;
      exp_ovf  = 1'b0;
    end else begin
      r        = alu_model(ctrl, a, b);
      exp_data = r.lo;
      exp_zero = r.zero;
      exp_ovf  = r.ovf;
      if (ctrl == ALU_MUL || ctrl == ALU_MULU) begin
        model_hi = r.hi;
        model_lo = r.lo;
      end
    end

    checkOutput("resp_data", 64'(resp_data), 64'(exp_data));
    checkOutput("resp_zero", 64'(resp_zero), 64'(exp_zero));
    checkOutput("resp_overflow", 64'(resp_overflow), 64'(exp_ovf));
    checkOutput("resp_err", 64'(resp_err), 64'(illegal));
    checkOutput("resp_tag", 64'(resp_tag), 64'(tag));
    checkOutput("hi_q", 64'(hi_q), 64'(model_hi));
    checkOutput("lo_q", 64'(lo_q), 64'(model_lo));
    checkOutput("resp_req_ready", 64'(req_ready), 64'd0);

    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_valid", 64'(resp_valid), 64'd1);
      checkOutput("stall_data", 64'(resp_data), 64'(exp_data));
      checkOutput("stall_flags", {61'd0, resp_zero, resp_overflow, resp_err},
                  {61'd0, exp_zero, exp_ovf, illegal});
      checkOutput("stall_tag", 64'(resp_tag), 64'(tag));
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
    end

    // A request offered during the handshake cycle must not be taken.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_ctrl   = ctrl ^ 5'd1;
    req_a      = ~a;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    checkOutput("post_hs_valid", 64'(resp_valid), 64'd0);
    checkOutput("post_hs_ready", 64'(req_ready), 64'd1);
    checkOutput("no_overlap_ctrl", 64'(alu_ctrl), 64'(ctrl));
    checkOutput("no_overlap_a", 64'(alu_a), 64'(a));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] rc;
    tests_run    = 0;
    tests_failed = 0;
    model_hi     = 32'd0;
    model_lo     = 32'd0;
    rst          = 1'b1;
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_ctrl     = ALU_ADD;
    req_a        = 32'h1234;
    req_b        = 32'h5678;
    req_tag      = 5'd3;

    // Reset wins over a simultaneous request.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_alu_ctrl", 64'(alu_ctrl), 64'(ALU_BUF));
    checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
    checkOutput("rst_alu_b", 64'(alu_b), 64'd0);
    checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
    checkOutput("rst_resp_flags", {59'd0, resp_tag}, 64'd0);
    checkOutput("rst_hi_lo", {hi_q, lo_q}, 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 64'(req_ready), 64'd1);
    checkOutput("post_rst_valid", 64'(resp_valid), 64'd0);
    checkOutput("post_rst_err", {61'd0, resp_zero, resp_overflow, resp_err}, 64'd0);

    // Directed corner cases.
    applyStimulus(ALU_ADD, 32'd5, 32'd7, 5'd3, 0);
    checkOutput("add_5_7", 64'(resp_data), 64'd12);
    checkOutput("add_5_7_flags", {62'd0, resp_zero, resp_overflow}, 64'd0);
    applyStimulus(ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd4, 1);
    checkOutput("add_ovf_data", 64'(resp_data), 64'h80000000);
    checkOutput("add_ovf_flag", 64'(resp_overflow), 64'd1);
    applyStimulus(ALU_MUL, 32'hFFFFFFFF, 32'd2, 5'd5, 0);
    checkOutput("mul_data", 64'(resp_data), 64'hFFFFFFFE);
    checkOutput("mul_hilo", {hi_q, lo_q}, 64'hFFFFFFFF_FFFFFFFE);
    applyStimulus(ALU_ADD, 32'd1, 32'd1, 5'd6, 0);
    checkOutput("add_keeps_hilo", {hi_q, lo_q}, 64'hFFFFFFFF_FFFFFFFE);
    applyStimulus(ALU_FP_FIRST, 32'h3F800000, 32'h40000000, 5'd7, 0);
    checkOutput("fp_add_data", 64'(resp_data), 64'h40400000);
    applyStimulus(5'd31, 32'hDEAD, 32'hBEEF, 5'd9, 0);
    checkOutput("illegal_resp", {resp_data, 27'd0, resp_tag}, {32'd0, 27'd0, 5'd9});
    checkOutput("illegal_err", {62'd0, resp_err, resp_zero}, 64'd3);
    checkOutput("illegal_hilo", {hi_q, lo_q}, 64'hFFFFFFFF_FFFFFFFE);
    applyStimulus(ALU_SUB, 32'd10, 32'd3, 5'd12, 4);
    checkOutput("sub_stall_data", 64'(resp_data), 64'd7);

    // Reset during EXEC of a multiply: no response and HI/LO cleared.
    req_valid = 1'b1;
    req_ctrl  = ALU_MUL;
    req_a     = 32'd3;
    req_b     = 32'd4;
    req_tag   = 5'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    checkOutput("midexec_rst_ready", 64'(req_ready), 64'd1);
    checkOutput("midexec_rst_hilo", {hi_q, lo_q}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("midexec_no_resp", 64'(resp_valid), 64'd0);
    end

    // Randomised traffic, biased towards the HI/LO-writing multiplies.
    for (int k = 0; k < 40; k++) begin
      rc = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rc = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_MULU;
      applyStimulus(rc, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
